// File: rtl/bridge_dir_ctrl.sv
// ---------------------------------------------------------------------------
// bridge_dir_ctrl
//   Direction controller for a single-lane shared resource (one-lane bridge)
//   fed from an east side and a west side. Only one direction owns the lane
//   at a time, and occupancy is tracked up to MAX_OCC. If the far side keeps
//   waiting, ownership is taken away after TIMEOUT cycles. The lane then
//   drains to empty before the direction reverses.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   E      in   1      east entry request (level, held until granted)
//   W      in   1      west entry request (level)
//   exit   in   1      one vehicle leaves the lane this cycle (pulse)
//   GO_E   out  1      east entry granted this cycle (combinational)
//   GO_W   out  1      west entry granted this cycle (combinational)
//   OUT    out  1      idle: no owner
//   dir    out  2      state encoding IDLE=00 EAST=01 WEST=10 DRAIN=11
//   occ    out  OCC_W  current occupancy
//   err    out  1      only with BRIDGE_ERR_EN: sticky protocol error
//
// Optional feature macro: BRIDGE_ERR_EN
//   When it is defined, the err port is added. err is set by an exit while
//   the lane is empty, or by E and W both held high for more than TIMEOUT
//   cycles in DRAIN. Only reset clears it.
//
// state | meaning
// IDLE  | no owner, lane empty, no grants
// EAST  | east owns the lane, east entries granted
// WEST  | west owns the lane, west entries granted
// DRAIN | waiting for the lane to empty before handing it to r_nxt
// ---------------------------------------------------------------------------
module bridge_dir_ctrl #(
  parameter int OCC_W   = 4,
  parameter int MAX_OCC = 8,
  parameter int TO_W    = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E,
  input  logic             W,
  input  logic             exit,
  output logic             GO_E,
  output logic             GO_W,
  output logic             OUT,
  output logic [1:0]       dir,
  output logic [OCC_W-1:0] occ
`ifdef BRIDGE_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EAST  = 2'b01,
    WEST  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam logic [OCC_W-1:0] MAX_Q   = OCC_W'(MAX_OCC);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  state_t            r_nxt, w_nxt_nxt;    // target direction held through DRAIN
  state_t            r_last, w_last_nxt;  // most recent owner, only EAST/WEST
  logic [TO_W-1:0]   r_timer, w_timer_nxt;
  logic [OCC_W-1:0]  r_occ;
  logic              w_leave;
  logic              w_not_full;
  logic              w_grant;
  logic              w_empty;
  logic [TO_W-1:0]   w_timer_inc;

  assign w_not_full  = (r_occ < MAX_Q);
  assign w_empty     = (r_occ == '0);
  // Saturate rather than wrap so a long wait can never look like a short one.
  assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_nxt_nxt   = r_nxt;
    w_last_nxt  = r_last;
    w_timer_nxt = '0;
    w_leave     = 1'b0;
    GO_E        = 1'b0;
    GO_W        = 1'b0;
    case (r_state)
      IDLE: begin
        if (E && !W)      w_state_nxt = EAST;
        else if (W && !E) w_state_nxt = WEST;
        else if (E && W)  w_state_nxt = (r_last == WEST) ? EAST : WEST;
      end
      EAST: begin
        w_leave = W && (!E || (r_timer == TO_LAST));
        GO_E    = E && w_not_full && !w_leave;
        if (w_leave) begin
          w_state_nxt = DRAIN;
          w_nxt_nxt   = WEST;
          w_last_nxt  = EAST;
        end else if (!E && !W && w_empty) begin
          w_state_nxt = IDLE;
          w_last_nxt  = EAST;
        end else begin
          w_timer_nxt = W ? w_timer_inc : '0;
        end
      end
      WEST: begin
        w_leave = E && (!W || (r_timer == TO_LAST));
        GO_W    = W && w_not_full && !w_leave;
        if (w_leave) begin
          w_state_nxt = DRAIN;
          w_nxt_nxt   = EAST;
          w_last_nxt  = WEST;
        end else if (!E && !W && w_empty) begin
          w_state_nxt = IDLE;
          w_last_nxt  = WEST;
        end else begin
          w_timer_nxt = E ? w_timer_inc : '0;
        end
      end
      DRAIN: begin
        if (w_empty) begin
          if ((r_nxt == EAST && E) || (r_nxt == WEST && W)) w_state_nxt = r_nxt;
          else                                               w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_grant = GO_E || GO_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_nxt   <= IDLE;
      r_last  <= WEST;
      r_timer <= '0;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_nxt   <= w_nxt_nxt;
      r_last  <= w_last_nxt;
      r_timer <= w_timer_nxt;
      // A grant already implies room, and an exit at zero is dropped.
      if (w_grant && !exit)               r_occ <= r_occ + 1'b1;
      else if (exit && !w_grant && !w_empty) r_occ <= r_occ - 1'b1;
    end
  end

`ifdef BRIDGE_ERR_EN
  logic [TO_W:0] r_dwait;  // cycles spent in DRAIN with both sides requesting

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwait <= '0;
      err     <= 1'b0;
    end else begin
      if (r_state == DRAIN && E && W) begin
        if (r_dwait == (TO_W+1)'(TIMEOUT)) err <= 1'b1;
        else                               r_dwait <= r_dwait + 1'b1;
      end else begin
        r_dwait <= '0;
      end
      if (exit && w_empty) err <= 1'b1;
    end
  end
`endif

  assign OUT = (r_state == IDLE);
  assign dir = r_state;
  assign occ = r_occ;

endmodule

// File: tb/tb_bridge_dir_ctrl.sv
module tb_bridge_dir_ctrl;
  logic       clk;
  logic       rst_n;
  logic       E, W, exit;
  logic       GO_E, GO_W, OUT;
  logic [1:0] dir;
  logic [3:0] occ;
`ifdef BRIDGE_ERR_EN
  logic       err;
`endif

  int n_vec;
  int n_bad;

  bridge_dir_ctrl #(.OCC_W(4), .MAX_OCC(8), .TO_W(5), .TIMEOUT(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .E    (E),
    .W    (W),
    .exit (exit),
    .GO_E (GO_E),
    .GO_W (GO_W),
    .OUT  (OUT),
    .dir  (dir),
    .occ  (occ)
`ifdef BRIDGE_ERR_EN
    ,
    .err  (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    E = 1'b0; W = 1'b0; exit = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Empties the lane with exit pulses and waits for IDLE, bounded.
  task automatic go_idle();
    int budget;
    E = 1'b0; W = 1'b0;
    budget = 0;
    while (occ != 4'd0 && budget < 20) begin
      exit = 1'b1; tick(); budget++;
    end
    exit = 1'b0;
    budget = 0;
    while (dir != 2'b00 && budget < 5) begin
      tick(); budget++;
    end
    n_vec++;
    if (dir !== 2'b00) begin
      n_bad++; $display("FAIL go_idle: dir=%b required 00", dir);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    n_vec++; if (OUT !== 1'b1)  begin n_bad++; $display("FAIL reset_out: got %b want 1", OUT); end
    n_vec++; if (dir !== 2'b00) begin n_bad++; $display("FAIL reset_dir: got %b want 00", dir); end
    n_vec++; if (occ !== 4'd0)  begin n_bad++; $display("FAIL reset_occ: got %0d want 0", occ); end
    n_vec++; if (GO_E !== 1'b0 || GO_W !== 1'b0) begin
      n_bad++; $display("FAIL reset_go: got %b%b want 00", GO_E, GO_W);
    end
`ifdef BRIDGE_ERR_EN
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
`endif
  endtask

  task automatic test_fill_east();
    logic exp_go;
    E = 1'b1; W = 1'b0; #1;
    n_vec++; if (GO_E !== 1'b0) begin n_bad++; $display("FAIL fill_idle_nogrant: got %b want 0", GO_E); end
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_go = (i < 8);
      n_vec++; if (dir !== 2'b01) begin n_bad++; $display("FAIL fill_dir[%0d]: got %b want 01", i, dir); end
      n_vec++; if (GO_E !== exp_go) begin n_bad++; $display("FAIL fill_go[%0d]: got %b want %b", i, GO_E, exp_go); end
      tick();
    end
    n_vec++; if (occ !== 4'd8) begin n_bad++; $display("FAIL fill_occ: got %0d want 8", occ); end
    go_idle();
  endtask

  task automatic test_alternation();
    // last owner is EAST here, so a tie goes west
    E = 1'b1; W = 1'b1;
    tick();
    n_vec++; if (dir !== 2'b10) begin n_bad++; $display("FAIL alt_dir: got %b want 10", dir); end
    go_idle();
  endtask

  task automatic test_timeout();
    logic exp_go;
    reset_dut();
    E = 1'b1; W = 1'b1; #1;
    n_vec++; if (GO_E !== 1'b0) begin n_bad++; $display("FAIL to_idle_nogrant: got %b want 0", GO_E); end
    tick();
    for (int i = 0; i < 16; i++) begin
      #1;
      exp_go = (i < 8);
      n_vec++; if (dir !== 2'b01) begin n_bad++; $display("FAIL to_east[%0d]: got %b want 01", i, dir); end
      n_vec++; if (GO_E !== exp_go) begin n_bad++; $display("FAIL to_go[%0d]: got %b want %b", i, GO_E, exp_go); end
      tick();
    end
    n_vec++; if (dir !== 2'b11) begin n_bad++; $display("FAIL to_drain: got %b want 11", dir); end
    n_vec++; if (occ !== 4'd8)  begin n_bad++; $display("FAIL to_occ: got %0d want 8", occ); end
    for (int i = 0; i < 8; i++) begin
      exit = 1'b1; #1;
      n_vec++; if (GO_E !== 1'b0 || GO_W !== 1'b0 || dir !== 2'b11) begin
        n_bad++; $display("FAIL to_drain_exit[%0d]: go=%b%b dir=%b want 00 11", i, GO_E, GO_W, dir);
      end
      tick();
    end
    exit = 1'b0; #1;
    n_vec++; if (dir !== 2'b11 || occ !== 4'd0) begin
      n_bad++; $display("FAIL to_drain_empty: dir=%b occ=%0d want 11 0", dir, occ);
    end
    tick();
    n_vec++; if (dir !== 2'b10) begin n_bad++; $display("FAIL to_west: got %b want 10", dir); end
    n_vec++; if (GO_W !== 1'b1) begin n_bad++; $display("FAIL to_gow: got %b want 1", GO_W); end
    tick();
    go_idle();
  endtask

  task automatic test_simul_grant_exit();
    E = 1'b1; W = 1'b0;
    tick();
    repeat (3) tick();
    n_vec++; if (occ !== 4'd3) begin n_bad++; $display("FAIL sim_pre: got %0d want 3", occ); end
    exit = 1'b1; #1;
    n_vec++; if (GO_E !== 1'b1) begin n_bad++; $display("FAIL sim_go: got %b want 1", GO_E); end
    tick();
    n_vec++; if (occ !== 4'd3) begin n_bad++; $display("FAIL sim_occ: got %0d want 3", occ); end
    E = 1'b0;
    repeat (3) tick();
    n_vec++; if (occ !== 4'd0) begin n_bad++; $display("FAIL sim_drain: got %0d want 0", occ); end
    tick();
    exit = 1'b0;
    n_vec++; if (occ !== 4'd0 || dir !== 2'b00) begin
      n_bad++; $display("FAIL sim_underflow: occ=%0d dir=%b want 0 00", occ, dir);
    end
`ifdef BRIDGE_ERR_EN
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL sim_err: got %b want 1", err); end
`endif
  endtask

  task automatic test_e_drop();
    E = 1'b1; W = 1'b0;
    tick();
    repeat (2) tick();
    E = 1'b0;
    tick();
    n_vec++; if (dir !== 2'b01 || occ !== 4'd2) begin
      n_bad++; $display("FAIL drop_hold: dir=%b occ=%0d want 01 2", dir, occ);
    end
    exit = 1'b1;
    repeat (2) tick();
    exit = 1'b0;
    n_vec++; if (dir !== 2'b01 || occ !== 4'd0) begin
      n_bad++; $display("FAIL drop_empty: dir=%b occ=%0d want 01 0", dir, occ);
    end
    tick();
    n_vec++; if (dir !== 2'b00 || OUT !== 1'b1) begin
      n_bad++; $display("FAIL drop_idle: dir=%b out=%b want 00 1", dir, OUT);
    end
  endtask

  task automatic test_reset_mid();
    E = 1'b1; W = 1'b0;
    tick();
    repeat (5) tick();
    n_vec++; if (occ !== 4'd5) begin n_bad++; $display("FAIL rmid_pre: got %0d want 5", occ); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (OUT !== 1'b1 || dir !== 2'b00 || occ !== 4'd0 || GO_E !== 1'b0 || GO_W !== 1'b0) begin
      n_bad++; $display("FAIL rmid_async: out=%b dir=%b occ=%0d go=%b%b want 1 00 0 00",
                        OUT, dir, occ, GO_E, GO_W);
    end
    E = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    E = 1'b0; W = 1'b0; exit = 1'b0; rst_n = 1'b0;
    test_reset();
    test_fill_east();
    test_alternation();
    test_timeout();
    test_simul_grant_exit();
    test_e_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
